nms_stream: RTL and testbench

- Pipelined, streaming non-maximum suppression stage with optional double-threshold classification.
- Sits between the gradient/angle stage and the hysteresis/edge-tracking stage.
- Consumes one 3x3 magnitude window plus the quantised gradient angle per transfer over a valid/ready handshake.
- Emits the thinned centre magnitude, an edge class and running statistics.
- Generalises the combinational NMS with:
  - parametrised pixel width;
  - a programmable tie rule;
  - programmable low/high thresholds;
  - backpressure;
  - a suppressed-pixel counter.

---
 rtl/nms_pkg.sv | 24 ++
 rtl/nms_pipe_stage.sv | 41 ++++
 rtl/nms_stream.sv | 146 ++++++++++++++
 tb/tb_nms_stream.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nms_pkg.sv
// ============================================================================
// nms_pkg : shared types and constants for the NMS streaming stage
// Revision: 1.0
// ============================================================================
`default_nettype none

package nms_pkg;

    typedef enum logic [1:0] {
        EDGE_NONE   = 2'd0,
        EDGE_WEAK   = 2'd1,
        EDGE_STRONG = 2'd2
    } edge_class_e;

    localparam logic [1:0] ANG_0   = 2'd0;
    localparam logic [1:0] ANG_45  = 2'd1;
    localparam logic [1:0] ANG_90  = 2'd2;
    localparam logic [1:0] ANG_135 = 2'd3;

    localparam int CENTER = 4;

endpackage

`default_nettype wire

// File: rtl/nms_pipe_stage.sv
// ============================================================================
// nms_pipe_stage : generic valid/ready register slice, payload held on stall
// Revision: 1.0
// ============================================================================
`default_nettype none

module nms_pipe_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    assign o_ready = !r_valid || i_ready;
    assign o_valid = r_valid;
    assign o_data  = r_data;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (o_ready) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_data <= i_data;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/nms_stream.sv
// ============================================================================
// nms_stream : two-stage streaming non-maximum suppression with thresholds
// Revision: 1.0
// ============================================================================
`default_nettype none

module nms_stream
    import nms_pkg::*;
#(
    parameter int BITS     = 8,
    parameter int CNT_BITS = 20
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                clear,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [1:0]          in_angle,
    input  logic [9*BITS-1:0]   in_mag,
    input  logic                tie_strict,
    input  logic                thr_en,
    input  logic [BITS-1:0]     thr_low,
    input  logic [BITS-1:0]     thr_high,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [BITS-1:0]     out_pixel,
    output logic [1:0]          out_class,
    output logic [CNT_BITS-1:0] pix_count,
    output logic [CNT_BITS-1:0] sup_count
);

    localparam int S1_W = 3*BITS + 1;
    localparam int S2_W = BITS + 3;

    logic [BITS-1:0] w_a;
    logic [BITS-1:0] w_b;
    logic [BITS-1:0] w_c;
    logic [S1_W-1:0] w_s1_in;
    logic [S1_W-1:0] w_s1_out;
    logic            w_s1_valid;
    logic            w_s2_ready;

    // Neighbour pair lies along the gradient direction through the centre
    always_comb begin
        w_a = in_mag[3*BITS +: BITS];
        w_b = in_mag[5*BITS +: BITS];
        case (in_angle)
            ANG_0:   begin w_a = in_mag[3*BITS +: BITS]; w_b = in_mag[5*BITS +: BITS]; end
            ANG_45:  begin w_a = in_mag[2*BITS +: BITS]; w_b = in_mag[6*BITS +: BITS]; end
            ANG_90:  begin w_a = in_mag[1*BITS +: BITS]; w_b = in_mag[7*BITS +: BITS]; end
            ANG_135: begin w_a = in_mag[0*BITS +: BITS]; w_b = in_mag[8*BITS +: BITS]; end
            default: begin w_a = in_mag[3*BITS +: BITS]; w_b = in_mag[5*BITS +: BITS]; end
        endcase
    end

    assign w_c     = in_mag[CENTER*BITS +: BITS];
    assign w_s1_in = {tie_strict, w_a, w_b, w_c};

    nms_pipe_stage #(.WIDTH(S1_W)) u_s1 (
        .clk     (clk),
        .n_rst   (n_rst),
        .i_valid (in_valid),
        .o_ready (in_ready),
        .i_data  (w_s1_in),
        .o_valid (w_s1_valid),
        .i_ready (w_s2_ready),
        .o_data  (w_s1_out)
    );

    logic            w_s1_tie;
    logic [BITS-1:0] w_s1_a;
    logic [BITS-1:0] w_s1_b;
    logic [BITS-1:0] w_s1_c;
    logic            w_sup;
    logic [BITS-1:0] w_pix;
    edge_class_e     w_cls;
    logic [S2_W-1:0] w_s2_in;
    logic [S2_W-1:0] w_s2_out;

    assign {w_s1_tie, w_s1_a, w_s1_b, w_s1_c} = w_s1_out;

    assign w_sup = w_s1_tie ? ((w_s1_a >= w_s1_c) || (w_s1_b >= w_s1_c))
                            : ((w_s1_a >  w_s1_c) || (w_s1_b >  w_s1_c));
    assign w_pix = w_sup ? '0 : w_s1_c;

    // Thresholds are read here, at the moment the second stage loads
    always_comb begin
        w_cls = EDGE_NONE;
        if (w_sup) begin
            w_cls = EDGE_NONE;
        end else if (!thr_en) begin
            w_cls = (w_pix != '0) ? EDGE_STRONG : EDGE_NONE;
        end else if (w_pix >= thr_high) begin
            w_cls = EDGE_STRONG;
        end else if (w_pix >= thr_low) begin
            w_cls = EDGE_WEAK;
        end
    end

    assign w_s2_in = {w_sup, w_cls, w_pix};

    nms_pipe_stage #(.WIDTH(S2_W)) u_s2 (
        .clk     (clk),
        .n_rst   (n_rst),
        .i_valid (w_s1_valid),
        .o_ready (w_s2_ready),
        .i_data  (w_s2_in),
        .o_valid (out_valid),
        .i_ready (out_ready),
        .o_data  (w_s2_out)
    );

    logic w_out_sup;
    logic w_xfer;

    assign out_pixel = w_s2_out[BITS-1:0];
    assign out_class = w_s2_out[BITS +: 2];
    assign w_out_sup = w_s2_out[BITS+2];
    assign w_xfer    = out_valid && out_ready;

    logic [CNT_BITS-1:0] r_pix_count;
    logic [CNT_BITS-1:0] r_sup_count;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_pix_count <= '0;
            r_sup_count <= '0;
        end else if (clear) begin
            r_pix_count <= '0;
            r_sup_count <= '0;
        end else if (w_xfer) begin
            if (r_pix_count != '1) begin
                r_pix_count <= r_pix_count + CNT_BITS'(1);
            end
            if (w_out_sup && (r_sup_count != '1)) begin
                r_sup_count <= r_sup_count + CNT_BITS'(1);
            end
        end
    end

    assign pix_count = r_pix_count;
    assign sup_count = r_sup_count;

endmodule

`default_nettype wire

// File: tb/tb_nms_stream.sv
// ============================================================================
// tb_nms_stream : randomized scoreboard bench for nms_stream
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_nms_stream;

    localparam int BITS = 8;
    localparam int CNTB = 4;
    localparam int CMAX = 15;

    logic            clk = 1'b0;
    logic            n_rst;
    logic            clear;
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      in_angle;
    logic [9*BITS-1:0] in_mag;
    logic            tie_strict;
    logic            thr_en;
    logic [BITS-1:0] thr_low;
    logic [BITS-1:0] thr_high;
    logic            out_valid;
    logic            out_ready;
    logic [BITS-1:0] out_pixel;
    logic [1:0]      out_class;
    logic [CNTB-1:0] pix_count;
    logic [CNTB-1:0] sup_count;

    nms_stream #(.BITS(BITS), .CNT_BITS(CNTB)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .clear      (clear),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_angle   (in_angle),
        .in_mag     (in_mag),
        .tie_strict (tie_strict),
        .thr_en     (thr_en),
        .thr_low    (thr_low),
        .thr_high   (thr_high),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_pixel  (out_pixel),
        .out_class  (out_class),
        .pix_count  (pix_count),
        .sup_count  (sup_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int pix;
        int cls;
        bit sup;
        int cyc;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    int   m_pix = 0;
    int   m_sup = 0;
    bit   chk_lat = 0;
    int   rmode = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: pick the gradient-direction pair, suppress, then classify
    function automatic exp_t model(input logic [9*BITS-1:0] m, input logic [1:0] ang,
                                   input logic tie, input logic te,
                                   input logic [BITS-1:0] lo, input logic [BITS-1:0] hi);
        exp_t e;
        int c, a, b;
        c = int'(m[4*BITS +: BITS]);
        a = int'(m[(3 - int'(ang))*BITS +: BITS]);
        b = int'(m[(5 + int'(ang))*BITS +: BITS]);
        e.sup = tie ? (a >= c || b >= c) : (a > c || b > c);
        e.pix = e.sup ? 0 : c;
        if (e.sup)                 e.cls = 0;
        else if (!te)              e.cls = (e.pix != 0) ? 2 : 0;
        else if (e.pix >= int'(hi)) e.cls = 2;
        else if (e.pix >= int'(lo)) e.cls = 1;
        else                       e.cls = 0;
        e.cyc = 0;
        return e;
    endfunction

    function automatic logic [9*BITS-1:0] win(input int ang, input int c, input int a,
                                              input int b, input int fill);
        logic [9*BITS-1:0] m;
        for (int i = 0; i < 9; i++) m[i*BITS +: BITS] = BITS'(fill);
        m[4*BITS +: BITS]         = BITS'(c);
        m[(3-ang)*BITS +: BITS]   = BITS'(a);
        m[(5+ang)*BITS +: BITS]   = BITS'(b);
        return m;
    endfunction

    function automatic logic [9*BITS-1:0] rnd_win();
        logic [9*BITS-1:0] m;
        for (int i = 0; i < 9; i++)
            m[i*BITS +: BITS] = ($urandom_range(0, 3) == 0) ? BITS'($urandom_range(0, 255))
                                                          : BITS'(100 + $urandom_range(0, 4));
        return m;
    endfunction

    // Input side: record expected result at each accepted window
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (n_rst && in_valid && in_ready) begin
                e = model(in_mag, in_angle, tie_strict, thr_en, thr_low, thr_high);
                e.cyc = cyc;
                q.push_back(e);
            end
        end
    end

    // Output side: scoreboard, stall stability, flow control and counters
    initial begin
        exp_t e;
        bit   held = 0;
        bit   xs;
        int   hpix = 0;
        int   hcls = 0;
        forever begin
            @(negedge clk);
            if (!n_rst) begin
                held = 0;
                continue;
            end
            chk("in_ready", int'(in_ready), (q.size() == 2 && !out_ready) ? 0 : 1);
            chk("pix_count", int'(pix_count), m_pix);
            chk("sup_count", int'(sup_count), m_sup);
            if (held && out_valid) begin
                chk("stall_pixel", int'(out_pixel), hpix);
                chk("stall_class", int'(out_class), hcls);
            end
            held = out_valid && !out_ready;
            hpix = int'(out_pixel);
            hcls = int'(out_class);
            xs = 0;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("spurious_out", 1, 0);
                end else begin
                    e  = q.pop_front();
                    xs = e.sup;
                    chk("out_pixel", int'(out_pixel), e.pix);
                    chk("out_class", int'(out_class), e.cls);
                    if (chk_lat) chk("latency", cyc - e.cyc, 2);
                end
            end
            if (clear) begin
                m_pix = 0;
                m_sup = 0;
            end else if (out_valid && out_ready) begin
                if (m_pix < CMAX) m_pix++;
                if (xs && m_sup < CMAX) m_sup++;
            end
        end
    end

    // Downstream readiness: always, periodic 1,0,0,1, or random
    initial begin
        int ph = 0;
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                1: begin out_ready = (ph % 4 == 0) || (ph % 4 == 3); ph++; end
                2: out_ready = ($urandom_range(0, 2) != 0);
                default: out_ready = 1'b1;
            endcase
        end
    end

    task automatic send(input logic [9*BITS-1:0] m, input logic [1:0] a, input logic t);
        int n  = 0;
        bit ok = 0;
        in_mag = m; in_angle = a; tie_strict = t; in_valid = 1'b1;
        while (!ok && n < 100) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!ok) chk("send_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || out_valid) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 200) chk("drain_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        idle(1);
        clear = 1'b0;
    endtask

    initial begin
        n_rst = 1'b0; clear = 1'b0; in_valid = 1'b0; in_angle = '0; in_mag = '0;
        tie_strict = 1'b0; thr_en = 1'b0; thr_low = '0; thr_high = '0;
        idle(3);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_pixel", int'(out_pixel), 0);
        chk("rst_out_class", int'(out_class), 0);
        chk("rst_pix_count", int'(pix_count), 0);
        chk("rst_sup_count", int'(sup_count), 0);
        n_rst = 1'b1;
        #1;
        chk("rst_in_ready", int'(in_ready), 1);
        idle(1);

        // Angle sweep with fixed latency
        chk_lat = 1;
        for (int a = 0; a < 4; a++) begin
            send(win(a, 100, 90, 95, 0), 2'(a), 1'b0);
            send(win(a, 100, (a % 2) ? 90 : 101, (a % 2) ? 101 : 95, 0), 2'(a), 1'b0);
        end
        drain();
        chk_lat = 0;
        chk("sweep_pix_count", int'(pix_count), 8);
        chk("sweep_sup_count", int'(sup_count), 4);

        // Tie rule
        send(win(1, 80, 80, 10, 0), 2'd1, 1'b0);
        send(win(1, 80, 80, 10, 0), 2'd1, 1'b1);
        drain();

        // Threshold bands
        thr_en = 1'b1; thr_low = 8'd50; thr_high = 8'd150;
        send(win(0, 49,  0, 0, 0), 2'd0, 1'b0);
        send(win(1, 50,  0, 0, 0), 2'd1, 1'b0);
        send(win(2, 149, 0, 0, 0), 2'd2, 1'b0);
        send(win(3, 150, 0, 0, 0), 2'd3, 1'b0);
        send(win(0, 255, 0, 0, 0), 2'd0, 1'b0);
        drain();
        thr_en = 1'b0;

        // Backpressure with periodic stalls
        pulse_clear();
        rmode = 1;
        for (int i = 0; i < 10; i++) send(rnd_win(), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        drain();
        rmode = 0;
        idle(1);
        chk("bp_pix_count", int'(pix_count), 10);

        // Counter saturation
        pulse_clear();
        for (int i = 0; i < 20; i++) send(win(i % 4, 5, 200, 200, 0), 2'(i % 4), 1'b0);
        drain();
        idle(1);
        chk("sat_sup_count", int'(sup_count), CMAX);
        chk("sat_pix_count", int'(pix_count), CMAX);

        // Clear on the same edge as an output transfer
        send(win(0, 60, 0, 0, 0), 2'd0, 1'b0);
        idle(1);
        chk("clr_coincide_valid", int'(out_valid), 1);
        pulse_clear();
        @(negedge clk);
        chk("clr_pix_count", int'(pix_count), 0);
        chk("clr_sup_count", int'(sup_count), 0);
        @(posedge clk);
        #1;

        // Randomized phases with random thresholds and downstream stalls
        rmode = 2;
        for (int p = 0; p < 4; p++) begin
            thr_en   = 1'($urandom_range(0, 1));
            thr_low  = BITS'($urandom_range(0, 255));
            thr_high = BITS'($urandom_range(0, 255));
            for (int i = 0; i < 60; i++) begin
                send(rnd_win(), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
                if ($urandom_range(0, 4) == 0) idle(1);
            end
            drain();
        end
        rmode = 0;
        idle(1);

        // Reset with two windows in flight
        send(rnd_win(), 2'd0, 1'b0);
        send(rnd_win(), 2'd2, 1'b1);
        #1;
        n_rst = 1'b0;
        q.delete();
        m_pix = 0;
        m_sup = 0;
        #1;
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_out_pixel", int'(out_pixel), 0);
        chk("midrst_pix_count", int'(pix_count), 0);
        chk("midrst_sup_count", int'(sup_count), 0);
        idle(2);
        n_rst = 1'b1;
        #1;
        chk("midrst_in_ready", int'(in_ready), 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("midrst_no_stale", int'(out_valid), 0);
        end
        idle(1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
